spi_byte_master: RTL and testbench
==================================

Name: spi_byte_master

Overview:
- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one 8-bit frame per start request.
- Sits directly upstream of the team's SPI slave receiver and drives its SCLK/MOSI/SS_n.
- Captures MISO into rx_data during the same frame.
- Host side is a start/busy/done handshake synchronous to the system clock.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range >= 2 so the slave's edge detector sees every SCLK edge.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  frame request; accepted only when busy=0
- tx_data  input  8  byte to send; sampled only in the accept cycle
- busy  output  1  high from the cycle after accept through the DONE cycle
- done  output  1  one-cycle pulse at frame end
- rx_data  output  8  byte shifted in from MISO; updated at frame end, held until the next frame ends
- SCLK  output  1  serial clock, idle low
- MOSI  output  1  serial data out
- MISO  input  1  serial data in
- SS_n  output  1  slave select, active low

Behaviour:
- Interface decisions:
  - One clock, clk.
  - Reset rst is asynchronous, active-high.
  - While rst=1, immediately: SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=8'h00, state=IDLE, counters=0.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- Phase counter: counts 0..CLK_DIV-1; width $clog2(CLK_DIV).
- Bit counter: 3 bits.
- IDLE:
  - SS_n=1, SCLK=0, MOSI=0, busy=0.
  - If start=1 in cycle N: latch tx_data into tx_shift and go to SETUP.
  - Cycle N+1: SS_n=0, busy=1, MOSI=tx_data[7].
- SETUP:
  - SCLK=0 for CLK_DIV cycles, then go to HIGH.
- HIGH:
  - SCLK=1 for CLK_DIV cycles.
  - On the last HIGH cycle, shift MISO into rx_shift LSB (rx_shift <= {rx_shift[6:0], MISO}).
  - Then go to LOW.
- LOW:
  - SCLK=0 for CLK_DIV cycles.
  - On the first LOW cycle, MOSI advances to the next bit (tx_shift shifts left).
  - After bit 0, MOSI holds its value until DONE.
  - At the end of LOW: if bit counter = 7, go to DONE; otherwise increment the bit counter and go to HIGH.
- DONE (one cycle):
  - SS_n=1, SCLK=0, MOSI=0, done=1, busy=1, rx_data <= rx_shift.
  - Next cycle: IDLE, busy=0.
- Frame timing (start accepted at cycle 0):
  - SS_n low during cycles 1 .. CLK_DIV*17.
  - Exactly 8 SCLK rising edges.
  - done in cycle CLK_DIV*17+1.
  - With CLK_DIV=4: SS_n low cycles 1..68, done at cycle 69, earliest next accept at cycle 70.
  - SS_n stays high >= 2 cycles between frames.
- Mode-0 guarantee: MOSI changes only while SCLK=0 (first LOW cycle or SETUP entry) and is stable across each entire HIGH phase.
- start while busy=1 (including the DONE cycle) is ignored. It is not queued, and tx_data changes mid-frame do not affect the frame.
- MISO is sampled only in HIGH. MISO values in other states have no effect.
- Reset asserted mid-frame aborts the frame: SS_n rises immediately and no done pulse occurs.

Test Plan:
- Reset check: hold rst=1 with random start/tx_data/MISO -> SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, rx_data=8'h00 throughout.
- Loopback, CLK_DIV=4, MISO tied to MOSI, start with tx_data=8'hA5 at cycle 0 ->
  - SS_n low cycles 1..68, 8 SCLK rising edges.
  - MOSI bits 1,0,1,0,0,1,0,1 stable across each HIGH phase.
  - done single pulse at cycle 69, rx_data=8'hA5, busy=0 at cycle 70.
- Connected to the team's SPI slave receiver, send 8'h3C -> slave rx_done pulses exactly once before master done; slave rx_data=8'h3C.
- Bench MISO model shifting 8'h5A out on SCLK falling edges (bit 7 presented at SS_n fall) -> master rx_data=8'h5A at done.
- Start pulsed again at cycle 20 with tx_data=8'hFF during an 8'h12 frame -> ignored; a single frame is observed with MOSI pattern 8'h12 and one done pulse.
- rst asserted at cycle 30 of a frame -> SS_n=1, SCLK=0 in the same cycle with no done pulse; after release, start with 8'h81 completes a normal 68-cycle frame with rx_data per MISO.

Source files
------------

// File: rtl/spi_byte_master.sv
// spi_byte_master: SPI mode-0 (CPOL=0, CPHA=0) master, MSB first, one byte per start.
// Rev 1.0 - initial release.
`default_nettype none

module spi_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS_n
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_shift;   // bits still to be sent; MOSI already holds the current one
  logic [7:0]    rx_shift;
  logic          phase_end;

  assign phase_end = (phase == PHASE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= 3'd0;
      tx_shift <= 7'd0;
      rx_shift <= 8'd0;
      rx_data  <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      SCLK     <= 1'b0;
      MOSI     <= 1'b0;
      SS_n     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= tx_data[6:0];
            MOSI     <= tx_data[7];
            SS_n     <= 1'b0;
            busy     <= 1'b1;
            phase    <= '0;
            bit_cnt  <= 3'd0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            phase <= '0;
            SCLK  <= 1'b1;
            state <= HIGH;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            phase    <= '0;
            SCLK     <= 1'b0;
            rx_shift <= {rx_shift[6:0], MISO};
            state    <= LOW;
            // Leaving the last bit on MOSI keeps it quiet until SS_n rises.
            if (bit_cnt != 3'd7) begin
              MOSI     <= tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        LOW: begin
          if (phase_end) begin
            phase <= '0;
            if (bit_cnt == 3'd7) begin
              SS_n    <= 1'b1;
              MOSI    <= 1'b0;
              done    <= 1'b1;
              rx_data <= rx_shift;
              state   <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              SCLK    <= 1'b1;
              state   <= HIGH;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          SS_n  <= 1'b1;
          SCLK  <= 1'b0;
          MOSI  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_master.sv
// tb_spi_byte_master: randomized scoreboard bench for spi_byte_master.
`default_nettype none

module tb_spi_byte_master;

  localparam int CLK_DIV = 4;
  localparam int FRAME_DONE = CLK_DIV * 17 + 1;
  localparam int SS_LOW_CYCLES = CLK_DIV * 17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       busy, done, SCLK, MOSI, SS_n;
  logic [7:0] rx_data;
  logic       MISO;

  spi_byte_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave-side MISO model: bit 7 presented when SS_n falls, next bit on each SCLK fall.
  logic       loopback = 1'b0;
  logic [7:0] miso_byte = 8'h00;
  logic [7:0] miso_sh = 8'h00;
  logic       miso_idle = 1'b0;
  always @(negedge SS_n) miso_sh = miso_byte;
  always @(negedge SCLK) if (!SS_n) miso_sh = {miso_sh[6:0], 1'b0};
  assign MISO = loopback ? MOSI : (SS_n ? miso_idle : miso_sh[7]);

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         c0;
  } exp_t;
  exp_t q[$];

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: observes the bus every cycle and scores each done against the queue.
  int         ss_low = 0, rises = 0, unstable = 0;
  logic [7:0] mosi_bits = 8'h00;
  logic       prev_sclk = 1'b0, hold = 1'b0, post_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      ss_low = 0; rises = 0; unstable = 0; mosi_bits = 8'h00;
      prev_sclk = 1'b0; post_done = 1'b0;
    end else begin
      if (post_done) begin
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_width", {31'd0, done}, 32'd0);
        post_done = 1'b0;
      end
      if (!SS_n) ss_low++;
      if (SCLK && !prev_sclk) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], MOSI};
        hold = MOSI;
      end else if (SCLK && (MOSI !== hold)) begin
        unstable++;
      end
      prev_sclk = SCLK;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.c0 + FRAME_DONE);
          chk("rx_data", {24'd0, rx_data}, {24'd0, e.rx});
          chk("mosi_pattern", {24'd0, mosi_bits}, {24'd0, e.tx});
          chk("sclk_rises", rises, 8);
          chk("ss_low_cycles", ss_low, SS_LOW_CYCLES);
          chk("mosi_stable", unstable, 0);
          chk("done_busy", {31'd0, busy}, 32'd1);
          chk("done_idle_bus", {29'd0, SS_n, SCLK, MOSI}, 32'b100);
        end
        ss_low = 0; rises = 0; unstable = 0;
        post_done = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !done) return;
      @(negedge clk);
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issues one frame; optionally pulses start with 8'hFF at cycle inject_at.
  task automatic send(input logic [7:0] tx, input logic [7:0] mb, input logic lb, input int inject_at);
    exp_t e;
    bit   seen;
    wait_idle();
    loopback  = lb;
    miso_byte = mb;
    tx_data   = tx;
    start     = 1'b1;
    e.tx = tx;
    e.rx = lb ? tx : mb;
    e.c0 = cyc;
    q.push_back(e);
    seen = 1'b0;
    for (int t = 1; t < 150 && !seen; t++) begin
      @(negedge clk);
      if (t == inject_at) begin
        start   = 1'b1;
        tx_data = 8'hFF;
      end else begin
        start   = 1'b0;
        tx_data = 8'($urandom);
      end
      miso_idle = 1'($urandom);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    // Reset held with random inputs: outputs must stay at their reset values.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start     = 1'($urandom);
      tx_data   = 8'($urandom);
      miso_idle = 1'($urandom);
      chk("reset_outputs", {27'd0, SS_n, SCLK, MOSI, busy, done}, 32'b10000);
      chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;

    send(8'hA5, 8'h00, 1'b1, -1);
    send(8'($urandom), 8'h5A, 1'b0, -1);
    for (int i = 0; i < 12; i++)
      send(8'($urandom), 8'($urandom), 1'($urandom), -1);
    send(8'h12, 8'($urandom), 1'b0, 20);

    // Abort a frame with reset at cycle 30.
    wait_idle();
    loopback  = 1'b0;
    miso_byte = 8'($urandom);
    tx_data   = 8'($urandom);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_bus", {29'd0, SS_n, SCLK, done}, 32'b100);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    send(8'h81, 8'($urandom), 1'b0, -1);
    send(8'($urandom), 8'($urandom), 1'b1, -1);

    repeat (100) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
